// File: rtl/ibuf_fetch_arbiter_if.sv
// Bundle of the requester-side and instruction-buffer-side signals of the
// fetch arbiter; master is the arbiter, slave is the surrounding logic.
interface ibuf_fetch_arbiter_if #(
  parameter int NUM_REQ = 4
);
  // Handshake: req[i] is a level held until its grant pulse. grant, done,
  // timeout_err and tag_err are single-cycle pulses. fetch_rd_en is a
  // one-cycle strobe the buffer always accepts (no ready). fetchwave_ack is a
  // one-cycle valid that qualifies wave_instr and wave_tag.
  logic [NUM_REQ-1:0]    req;
  logic [32*NUM_REQ-1:0] req_addr;
  logic [39*NUM_REQ-1:0] req_tag;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    done;
  logic [31:0]           done_instr;
  logic [38:0]           done_tag;
  logic                  timeout_err;
  logic [3:0]            err_id;
  logic                  tag_err;
  logic                  fetch_rd_en;
  logic [31:0]           fetch_addr;
  logic [38:0]           fetch_tag;
  logic                  fetchwave_ack;
  logic [31:0]           wave_instr;
  logic [38:0]           wave_tag;
  logic [1:0]            dbg_state;

  modport master (
    input  req, req_addr, req_tag, fetchwave_ack, wave_instr, wave_tag,
    output grant, done, done_instr, done_tag, timeout_err, err_id, tag_err,
    output fetch_rd_en, fetch_addr, fetch_tag, dbg_state
  );

  modport slave (
    output req, req_addr, req_tag, fetchwave_ack, wave_instr, wave_tag,
    input  grant, done, done_instr, done_tag, timeout_err, err_id, tag_err,
    input  fetch_rd_en, fetch_addr, fetch_tag, dbg_state
  );
endinterface

// File: rtl/ibuf_fetch_arbiter.sv
// Round-robin sequencer sharing the single instruction-buffer fetch port;
// one fetch outstanding, tag-checked responses and a wait watchdog.
module ibuf_fetch_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input logic                   clk,
  input logic                   rst,
  ibuf_fetch_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t              state;
  logic [3:0]          cur_id;
  logic [3:0]          rr_ptr;
  logic [31:0]         cur_addr;
  logic [38:0]         cur_tag;
  logic [7:0]          wait_cnt;

  logic [15:0]         req_pad;
  logic [4:0]          cand;
  logic                pick_valid;
  logic [3:0]          pick_id;
  logic [31:0]         pick_addr;
  logic [38:0]         pick_tag;
  logic [NUM_REQ-1:0]  pick_oh;
  logic [NUM_REQ-1:0]  cur_oh;
  logic                tag_match;

  assign bus.dbg_state = state;

  // Search rr_ptr+1, rr_ptr+2, ... wrapping at NUM_REQ; first set bit wins.
  always_comb begin
    req_pad    = 16'(bus.req);
    pick_valid = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + 5'(k);
      if (cand >= 5'(NUM_REQ)) cand = cand - 5'(NUM_REQ);
      if (!pick_valid && req_pad[cand[3:0]]) begin
        pick_valid = 1'b1;
        pick_id    = cand[3:0];
      end
    end
  end

  always_comb begin
    pick_addr = '0;
    pick_tag  = '0;
    pick_oh   = '0;
    cur_oh    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (4'(i) == pick_id) begin
        pick_addr  = bus.req_addr[32*i +: 32];
        pick_tag   = bus.req_tag[39*i +: 39];
        pick_oh[i] = 1'b1;
      end
      if (4'(i) == cur_id) cur_oh[i] = 1'b1;
    end
  end

  assign tag_match = bus.fetchwave_ack && (bus.wave_tag == cur_tag);

  // grant and fetch_* are loaded on the IDLE->ISSUE edge so they are high
  // exactly during the ISSUE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      cur_id          <= '0;
      cur_addr        <= '0;
      cur_tag         <= '0;
      rr_ptr          <= 4'(NUM_REQ-1);
      wait_cnt        <= '0;
      bus.grant       <= '0;
      bus.done        <= '0;
      bus.done_instr  <= '0;
      bus.done_tag    <= '0;
      bus.timeout_err <= 1'b0;
      bus.err_id      <= '0;
      bus.tag_err     <= 1'b0;
      bus.fetch_rd_en <= 1'b0;
      bus.fetch_addr  <= '0;
      bus.fetch_tag   <= '0;
    end else begin
      bus.grant       <= '0;
      bus.done        <= '0;
      bus.timeout_err <= 1'b0;
      bus.tag_err     <= 1'b0;
      bus.fetch_rd_en <= 1'b0;
      case (state)
        IDLE: begin
          bus.tag_err <= bus.fetchwave_ack;
          if (pick_valid) begin
            cur_id          <= pick_id;
            cur_addr        <= pick_addr;
            cur_tag         <= pick_tag;
            rr_ptr          <= pick_id;
            bus.grant       <= pick_oh;
            bus.fetch_rd_en <= 1'b1;
            bus.fetch_addr  <= pick_addr;
            bus.fetch_tag   <= pick_tag;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          bus.tag_err <= bus.fetchwave_ack;
          wait_cnt    <= '0;
          state       <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (tag_match) begin
            // A matching ack on the watchdog cycle still completes normally.
            bus.done       <= cur_oh;
            bus.done_instr <= bus.wave_instr;
            bus.done_tag   <= bus.wave_tag;
            state          <= IDLE;
          end else begin
            bus.tag_err <= bus.fetchwave_ack;
            if (wait_cnt == 8'(TIMEOUT-1)) begin
              bus.timeout_err <= 1'b1;
              bus.err_id      <= cur_id;
              state           <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ibuf_fetch_arbiter.sv
// Self-checking bench for ibuf_fetch_arbiter: vector table, hand sequences
// and randomized traffic against a cycle-numbered reference model.
module tb_ibuf_fetch_arbiter;
  localparam int NR  = 4;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ibuf_fetch_arbiter_if #(.NUM_REQ(NR)) bus();
  ibuf_fetch_arbiter #(.NUM_REQ(NR), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    int          id;
    logic [31:0] addr;
    logic [38:0] tag;
    int          lat;           // WAIT cycles before ack; -2 = never
    bit          bad;           // wrong-tag ack on the first WAIT cycle
    int          exp_done_dly;  // cycles from grant to done, -1 = none
    int          exp_tout_dly;  // cycles from grant to timeout_err, -1 = none
    int          exp_tagerr;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [7:0]  mem [256];
  logic [3:0]  req_v;
  logic [31:0] r_addr [NR];
  logic [38:0] r_tag  [NR];
  bit          hold_mode, rand_mode, bad_pending;
  int          lat_cfg, ack_at, inj_at;
  logic [31:0] ack_addr;
  logic [38:0] ack_tag, inj_tag, bad_tag, tag_ctr;

  // Reference model: last grant, cycle of the current grant, busy flag.
  bit          m_busy;
  int          m_id, m_g, m_ptr;
  logic [38:0] m_tag, m_last_tag;
  logic [31:0] m_last_addr;
  logic [3:0]  prev_req;
  bit          prev_ack;
  logic [38:0] prev_ack_tag;
  logic [70:0] exp_q [$];
  int          grant_log [$];
  int          ev_grant, ev_done, ev_tout, ev_tagerr_n;
  logic [31:0] last_instr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [7:0] b;
    b = {a[7:2], 2'b00};
    return {mem[8'(b + 8'd3)], mem[8'(b + 8'd2)], mem[8'(b + 8'd1)], mem[b]};
  endfunction

  function automatic int rr_pick(input logic [3:0] r, input int ptr);
    int c;
    for (int k = 1; k <= NR; k++) begin
      c = (ptr + k) % NR;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic apply_req();
    bus.req = req_v;
    for (int i = 0; i < NR; i++) begin
      bus.req_addr[32*i +: 32] = r_addr[i];
      bus.req_tag[39*i +: 39]  = r_tag[i];
    end
    prev_req = req_v;
  endtask

  task automatic model_reset();
    req_v = '0; ack_at = -1; inj_at = -1; bad_pending = 0;
    m_busy = 0; m_ptr = NR-1; m_id = 0; m_g = 0; m_tag = '0;
    m_last_addr = '0; m_last_tag = '0;
    prev_ack = 0; prev_ack_tag = '0;
    exp_q.delete();
    bus.fetchwave_ack = 1'b0; bus.wave_instr = '0; bus.wave_tag = '0;
    apply_req();
  endtask

  task automatic chk_all_zero(input string p);
    chk({p, "_grant"}, 64'(bus.grant), 0);
    chk({p, "_done"}, 64'(bus.done), 0);
    chk({p, "_done_instr"}, 64'(bus.done_instr), 0);
    chk({p, "_done_tag"}, 64'(bus.done_tag), 0);
    chk({p, "_timeout_err"}, 64'(bus.timeout_err), 0);
    chk({p, "_err_id"}, 64'(bus.err_id), 0);
    chk({p, "_tag_err"}, 64'(bus.tag_err), 0);
    chk({p, "_fetch_rd_en"}, 64'(bus.fetch_rd_en), 0);
    chk({p, "_fetch_addr"}, 64'(bus.fetch_addr), 0);
    chk({p, "_fetch_tag"}, 64'(bus.fetch_tag), 0);
    chk({p, "_state_idle"}, 64'(bus.dbg_state), 0);
  endtask

  // Requesters and instruction buffer react to what the DUT just showed.
  task automatic drive();
    int l;
    if (!hold_mode) req_v = req_v & ~bus.grant;
    if (rand_mode) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_v[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            tag_ctr   = tag_ctr + 39'd1;
            r_addr[i] = $urandom;
            r_tag[i]  = tag_ctr;
            req_v[i]  = 1'b1;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req_v[i] = 1'b0;
        end
      end
    end
    bus.fetchwave_ack = 1'b0;
    bus.wave_tag      = 39'($urandom);
    bus.wave_instr    = $urandom;
    if (cyc == ack_at) begin
      bus.fetchwave_ack = 1'b1;
      bus.wave_tag      = ack_tag;
      bus.wave_instr    = word_at(ack_addr);
      ack_at            = -1;
    end else if (cyc == inj_at) begin
      bus.fetchwave_ack = 1'b1;
      bus.wave_tag      = inj_tag;
      inj_at            = -1;
    end
    if (bus.fetch_rd_en) begin
      l = lat_cfg;
      if (l == -1) l = ($urandom_range(0, 7) == 0) ? -2 : int'($urandom_range(0, TMO+1));
      if (l >= 0) begin
        ack_at   = cyc + 1 + l;
        ack_tag  = bus.fetch_tag;
        ack_addr = bus.fetch_addr;
      end
      if (bad_pending) begin
        inj_at      = cyc + 1;
        inj_tag     = bad_tag;
        bad_pending = 0;
      end
    end
    prev_ack     = bus.fetchwave_ack;
    prev_ack_tag = bus.wave_tag;
    apply_req();
  endtask

  task automatic tick();
    logic [3:0]  eg, ed;
    logic [70:0] e;
    bit          match, et, etag;
    int          id;
    @(posedge clk);
    #1;
    cyc++;
    eg = '0;
    id = -1;
    if (!m_busy && |prev_req) begin
      id = rr_pick(prev_req, m_ptr);
      eg = 4'b0001 << id;
    end
    match = prev_ack && m_busy && (prev_ack_tag == m_tag) &&
            ((cyc-1) >= m_g+1) && ((cyc-1) <= m_g+TMO);
    ed    = match ? (4'b0001 << m_id) : 4'b0000;
    etag  = prev_ack && !match;
    et    = m_busy && !match && (cyc == m_g+TMO+1);
    chk("grant", 64'(bus.grant), 64'(eg));
    chk("fetch_rd_en", 64'(bus.fetch_rd_en), 64'(|eg));
    if (id >= 0) begin
      chk("fetch_addr", 64'(bus.fetch_addr), 64'(r_addr[id]));
      chk("fetch_tag", 64'(bus.fetch_tag), 64'(r_tag[id]));
    end else begin
      chk("fetch_addr_hold", 64'(bus.fetch_addr), 64'(m_last_addr));
      chk("fetch_tag_hold", 64'(bus.fetch_tag), 64'(m_last_tag));
    end
    chk("done", 64'(bus.done), 64'(ed));
    chk("tag_err", 64'(bus.tag_err), 64'(etag));
    chk("timeout_err", 64'(bus.timeout_err), 64'(et));
    if (match) begin
      e = exp_q.pop_front();
      chk("done_tag", 64'(bus.done_tag), 64'(e[70:32]));
      chk("done_instr", 64'(bus.done_instr), 64'(e[31:0]));
      last_instr = bus.done_instr;
      ev_done    = cyc;
      m_busy     = 0;
    end
    if (et) begin
      chk("err_id", 64'(bus.err_id), 64'(m_id));
      void'(exp_q.pop_front());
      ev_tout = cyc;
      m_busy  = 0;
    end
    if (bus.tag_err) ev_tagerr_n++;
    if (id >= 0) begin
      m_busy = 1; m_id = id; m_g = cyc; m_ptr = id; m_tag = r_tag[id];
      m_last_addr = r_addr[id];
      m_last_tag  = r_tag[id];
      exp_q.push_back({r_tag[id], word_at(r_addr[id])});
      grant_log.push_back(id);
      ev_grant = cyc;
    end
    drive();
  endtask

  task automatic clear_ev();
    ev_grant = -1; ev_done = -1; ev_tout = -1; ev_tagerr_n = 0;
  endtask

  vec_t vt [7];
  int   ford [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int start, dly_d, dly_t, bound;
    vt[0] = '{1, 32'h4,  39'd1,              2,  0, 4, -1, 0};
    vt[1] = '{0, 32'h10, 39'h7F_FFFF_FFFF,   0,  0, 2, -1, 0};
    vt[2] = '{2, 32'h20, 39'd2,             -2,  0, -1, 5, 0};
    vt[3] = '{3, 32'h30, 39'd5,              2,  1, 4, -1, 1};
    vt[4] = '{1, 32'h40, 39'd6,              3,  0, 5, -1, 0};
    vt[5] = '{2, 32'hFC, 39'd8,              1,  0, 3, -1, 0};
    vt[6] = '{0, 32'h50, 39'd9,              4,  0, -1, 5, 1};

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[4] = 8'h0A; mem[5] = 8'h0B; mem[6] = 8'h0C; mem[7] = 8'h0D;
    for (int i = 0; i < NR; i++) begin
      r_addr[i] = 32'h80 + 32'(4*i);
      r_tag[i]  = 39'h10 + 39'(i);
    end
    hold_mode = 0; rand_mode = 0; lat_cfg = 1; tag_ctr = 39'h1000; bad_tag = 39'd7;
    clear_ev();

    // Clock/reset.
    rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Fairness: all requests held, grants must rotate from requester 0.
    hold_mode = 1; lat_cfg = 1; req_v = 4'hF;
    apply_req();
    bound = 0;
    while (grant_log.size() < 6 && bound < 60) begin tick(); bound++; end
    hold_mode = 0; req_v = '0;
    apply_req();
    repeat (8) tick();
    chk("fair_count", 64'(grant_log.size() >= 6), 1);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      chk($sformatf("fair_order%0d", i), 64'(grant_log[i]), 64'(ford[i]));

    // Vector table: single fetch per vector.
    for (int i = 0; i < 7; i++) begin
      clear_ev();
      r_addr[vt[i].id] = vt[i].addr;
      r_tag[vt[i].id]  = vt[i].tag;
      req_v            = 4'b0001 << vt[i].id;
      lat_cfg          = vt[i].lat;
      bad_pending      = vt[i].bad;
      apply_req();
      start = cyc;
      repeat (12) tick();
      dly_d = (ev_done < 0) ? -1 : ev_done - ev_grant;
      dly_t = (ev_tout < 0) ? -1 : ev_tout - ev_grant;
      chk($sformatf("vec%0d_grant_lat", i), 64'(ev_grant - start), 1);
      chk($sformatf("vec%0d_done_dly", i), 64'(dly_d), 64'(vt[i].exp_done_dly));
      chk($sformatf("vec%0d_tout_dly", i), 64'(dly_t), 64'(vt[i].exp_tout_dly));
      chk($sformatf("vec%0d_tag_errs", i), 64'(ev_tagerr_n), 64'(vt[i].exp_tagerr));
      if (i == 0) chk("vec0_instr", 64'(last_instr), 64'h0D0C_0B0A);
    end

    // Stray ack while idle.
    clear_ev();
    inj_at = cyc + 1; inj_tag = 39'd3;
    repeat (4) tick();
    chk("stray_tag_errs", 64'(ev_tagerr_n), 1);
    chk("stray_no_done", 64'(ev_done), 64'(-1));

    // Asynchronous reset while waiting on an ack.
    lat_cfg = -2; req_v = 4'b0010;
    apply_req();
    bound = 0;
    while (!(m_busy && cyc >= m_g + 2) && bound < 10) begin tick(); bound++; end
    chk("arst_in_wait", 64'(m_busy), 1);
    #3 rst = 1'b0;
    #1 chk_all_zero("arst");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    grant_log.delete();
    lat_cfg = 0; req_v = 4'b1001;
    apply_req();
    repeat (16) tick();
    chk("arst_grants", 64'(grant_log.size() >= 2), 1);
    if (grant_log.size() >= 2) begin
      chk("arst_first", 64'(grant_log[0]), 0);
      chk("arst_second", 64'(grant_log[1]), 3);
    end

    // Randomized traffic with random, missing and late acks.
    rand_mode = 1; lat_cfg = -1;
    repeat (800) tick();
    rand_mode = 0;
    bound = 0;
    while ((req_v != 4'b0000 || m_busy) && bound < 120) begin tick(); bound++; end
    repeat (TMO + 4) tick();
    chk("rand_drain_req", 64'(req_v), 0);
    chk("rand_drain_busy", 64'(m_busy), 0);
    chk("sb_empty", 64'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
